// File: rtl/mc_ar_arbiter_if.sv
// +---------------------------------------------------------------------------+
// | mc_ar_arbiter_if -- requester AR channels and controller AR/R-done signals|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface mc_ar_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 16
);
  logic [ID_WIDTH-1:0]   arid0_i;
  logic [ADDR_WIDTH-1:0] araddr0_i;
  logic [7:0]            arlen0_i;
  logic                  arvalid0_i;
  logic                  arready0_o;

  logic [ID_WIDTH-1:0]   arid1_i;
  logic [ADDR_WIDTH-1:0] araddr1_i;
  logic [7:0]            arlen1_i;
  logic                  arvalid1_i;
  logic                  arready1_o;

  logic [ID_WIDTH-1:0]   arid_o;
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic [7:0]            arlen_o;
  logic                  arvalid_o;
  logic                  arready_i;
  logic                  rdone_i;

  // Arbiter side
  modport slave (
    input  arid0_i, araddr0_i, arlen0_i, arvalid0_i,
    input  arid1_i, araddr1_i, arlen1_i, arvalid1_i,
    input  arready_i, rdone_i,
    output arready0_o, arready1_o,
    output arid_o, araddr_o, arlen_o, arvalid_o
  );

  // Requesters plus memory controller side
  modport master (
    output arid0_i, araddr0_i, arlen0_i, arvalid0_i,
    output arid1_i, araddr1_i, arlen1_i, arvalid1_i,
    output arready_i, rdone_i,
    input  arready0_o, arready1_o,
    input  arid_o, araddr_o, arlen_o, arvalid_o
  );
endinterface

`default_nettype wire

// File: rtl/mc_ar_arbiter.sv
// +---------------------------------------------------------------------------+
// | mc_ar_arbiter -- round-robin AR arbiter with outstanding-burst limit      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mc_ar_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_ar_arbiter_if.slave      bus,
  output logic                grant_src_o,
  output logic [7:0]          outstanding_o,
  output logic                err_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  logic [0:0]            state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic                  arready0_q, arready0_d;
  logic                  arready1_q, arready1_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  src_q, src_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic w_grant;
  logic w_winner;
  logic w_hs;

  always_comb begin
    w_grant = (state_q == S_IDLE) && (bus.arvalid0_i || bus.arvalid1_i)
              && (cnt_q < MAX_CNT);
    // On a tie the requester that did not win last time goes first
    if (bus.arvalid0_i && bus.arvalid1_i) begin
      w_winner = ~last_q;
    end else begin
      w_winner = bus.arvalid1_i;
    end
    w_hs = (state_q == S_ISSUE) && arvalid_q && bus.arready_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      arvalid_q  <= 1'b0;
      arready0_q <= 1'b0;
      arready1_q <= 1'b0;
      arid_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      src_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      arready0_q <= arready0_d;
      arready1_q <= arready1_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      src_q      <= src_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_grant) state_d = S_ISSUE;
      S_ISSUE: if (w_hs)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid_d  = arvalid_q;
    arready0_d = 1'b0;
    arready1_d = 1'b0;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    src_d      = src_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    if (w_grant) begin
      arid_d     = w_winner ? bus.arid1_i   : bus.arid0_i;
      araddr_d   = w_winner ? bus.araddr1_i : bus.araddr0_i;
      arlen_d    = w_winner ? bus.arlen1_i  : bus.arlen0_i;
      src_d      = w_winner;
      last_d     = w_winner;
      arvalid_d  = 1'b1;
      arready0_d = ~w_winner;
      arready1_d = w_winner;
    end

    if (w_hs) begin
      arvalid_d = 1'b0;
    end

    // A completion in the same cycle as an issue cancels out
    case ({w_hs, bus.rdone_i})
      2'b10: cnt_d = cnt_q + 8'd1;
      2'b01: begin
        if (cnt_q == 8'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  assign bus.arvalid_o  = arvalid_q;
  assign bus.arready0_o = arready0_q;
  assign bus.arready1_o = arready1_q;
  assign bus.arid_o     = arid_q;
  assign bus.araddr_o   = araddr_q;
  assign bus.arlen_o    = arlen_q;
  assign grant_src_o    = src_q;
  assign outstanding_o  = cnt_q;
  assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ar_arbiter.sv
// +---------------------------------------------------------------------------+
// | tb_mc_ar_arbiter -- directed self-checking bench for mc_ar_arbiter        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mc_ar_arbiter;

  logic       clk;
  logic       rst_n;
  logic       gs, gs2;
  logic [7:0] os, os2;
  logic       er, er2;

  int n_chk  = 0;
  int n_fail = 0;

  mc_ar_arbiter_if #(.ADDR_WIDTH(64), .ID_WIDTH(16)) bus  ();
  mc_ar_arbiter_if #(.ADDR_WIDTH(64), .ID_WIDTH(16)) bus2 ();

  mc_ar_arbiter #(.ADDR_WIDTH(64), .ID_WIDTH(16), .MAX_OUTSTANDING(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .grant_src_o  (gs),
    .outstanding_o(os),
    .err_o        (er)
  );

  mc_ar_arbiter #(.ADDR_WIDTH(64), .ID_WIDTH(16), .MAX_OUTSTANDING(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus2),
    .grant_src_o  (gs2),
    .outstanding_o(os2),
    .err_o        (er2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.arid0_i  = '0; bus.araddr0_i  = '0; bus.arlen0_i  = '0; bus.arvalid0_i  = 1'b0;
    bus.arid1_i  = '0; bus.araddr1_i  = '0; bus.arlen1_i  = '0; bus.arvalid1_i  = 1'b0;
    bus.arready_i  = 1'b0; bus.rdone_i  = 1'b0;
    bus2.arid0_i = '0; bus2.araddr0_i = '0; bus2.arlen0_i = '0; bus2.arvalid0_i = 1'b0;
    bus2.arid1_i = '0; bus2.araddr1_i = '0; bus2.arlen1_i = '0; bus2.arvalid1_i = 1'b0;
    bus2.arready_i = 1'b0; bus2.rdone_i = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_arvalid", 64'(bus.arvalid_o), 64'd0);
    check("rst_arready0", 64'(bus.arready0_o), 64'd0);
    check("rst_arready1", 64'(bus.arready1_o), 64'd0);
    check("rst_araddr", bus.araddr_o, 64'd0);
    check("rst_arid", 64'(bus.arid_o), 64'd0);
    check("rst_arlen", 64'(bus.arlen_o), 64'd0);
    check("rst_src", 64'(gs), 64'd0);
    check("rst_cnt", 64'(os), 64'd0);
    check("rst_err", 64'(er), 64'd0);
    rst_n = 1'b1;

    // Both requesters valid: grants alternate starting with requester 0
    bus.arid0_i = 16'd1; bus.araddr0_i = 64'hA000; bus.arlen0_i = 8'd1;
    bus.arid1_i = 16'd2; bus.araddr1_i = 64'hB000; bus.arlen1_i = 8'd2;
    bus.arvalid0_i = 1'b1; bus.arvalid1_i = 1'b1; bus.arready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_src", 64'(gs), 64'(i % 2));
      check("rr_arready0", 64'(bus.arready0_o), 64'((i % 2) == 0));
      check("rr_arready1", 64'(bus.arready1_o), 64'((i % 2) == 1));
      check("rr_araddr", bus.araddr_o, (i % 2) ? 64'hB000 : 64'hA000);
      check("rr_arvalid", 64'(bus.arvalid_o), 64'd1);
      tick();
      check("rr_cnt", 64'(os), 64'(i + 1));
      check("rr_arvalid_drop", 64'(bus.arvalid_o), 64'd0);
      check("rr_arready_drop", 64'(bus.arready0_o | bus.arready1_o), 64'd0);
    end
    bus.arvalid0_i = 1'b0; bus.arvalid1_i = 1'b0;

    // rdone alone decrements; rdone coincident with a handshake holds
    bus.rdone_i = 1'b1; tick(); bus.rdone_i = 1'b0;
    check("rdone_dec", 64'(os), 64'd3);
    bus.arvalid0_i = 1'b1; tick(); bus.arvalid0_i = 1'b0;
    bus.rdone_i = 1'b1; tick(); bus.rdone_i = 1'b0;
    check("hs_rdone_cnt", 64'(os), 64'd3);
    check("hs_rdone_arvalid", 64'(bus.arvalid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.rdone_i = 1'b1; tick(); bus.rdone_i = 1'b0;
    end
    check("drain_cnt", 64'(os), 64'd0);
    check("drain_err", 64'(er), 64'd0);

    // Underflow sets a sticky error
    bus.rdone_i = 1'b1; tick(); bus.rdone_i = 1'b0;
    check("uflow_err", 64'(er), 64'd1);
    check("uflow_cnt", 64'(os), 64'd0);
    tick(); tick();
    check("uflow_sticky", 64'(er), 64'd1);

    rst_n = 1'b0; tick();
    check("rst_err_clear", 64'(er), 64'd0);
    rst_n = 1'b1;

    // Single requester 0 transaction
    bus.arid0_i = 16'd3; bus.araddr0_i = 64'h1000; bus.arlen0_i = 8'd3;
    bus.arvalid0_i = 1'b1; bus.arready_i = 1'b1;
    tick();
    check("r0_arready0", 64'(bus.arready0_o), 64'd1);
    check("r0_arready1", 64'(bus.arready1_o), 64'd0);
    check("r0_araddr", bus.araddr_o, 64'h1000);
    check("r0_arlen", 64'(bus.arlen_o), 64'd3);
    check("r0_arid", 64'(bus.arid_o), 64'd3);
    check("r0_src", 64'(gs), 64'd0);
    check("r0_arvalid", 64'(bus.arvalid_o), 64'd1);
    check("r0_cnt_before", 64'(os), 64'd0);
    bus.arvalid0_i = 1'b0;
    tick();
    check("r0_arready0_pulse", 64'(bus.arready0_o), 64'd0);
    check("r0_arvalid_drop", 64'(bus.arvalid_o), 64'd0);
    check("r0_cnt_after", 64'(os), 64'd1);

    // Back-pressure: held transaction is stable and requester inputs ignored
    bus.arready_i = 1'b0;
    bus.arid1_i = 16'd9; bus.araddr1_i = 64'h2000; bus.arlen1_i = 8'd7; bus.arvalid1_i = 1'b1;
    tick();
    check("stall_src", 64'(gs), 64'd1);
    check("stall_arready1", 64'(bus.arready1_o), 64'd1);
    bus.arvalid1_i = 1'b0; bus.araddr1_i = 64'hDEAD;
    bus.arvalid0_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_arvalid", 64'(bus.arvalid_o), 64'd1);
      check("stall_araddr", bus.araddr_o, 64'h2000);
      check("stall_arlen", 64'(bus.arlen_o), 64'd7);
      check("stall_src_hold", 64'(gs), 64'd1);
      check("stall_no_ready", 64'(bus.arready0_o | bus.arready1_o), 64'd0);
    end
    bus.arready_i = 1'b1; bus.arvalid0_i = 1'b0;
    tick();
    check("stall_hs_arvalid", 64'(bus.arvalid_o), 64'd0);
    check("stall_hs_cnt", 64'(os), 64'd2);
    tick();
    check("stall_single_hs", 64'(os), 64'd2);

    // Build up to 5 outstanding with one more transaction pending from requester 0
    bus.arvalid0_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); tick();
    end
    check("fill5_cnt", 64'(os), 64'd5);
    bus.arready_i = 1'b0;
    tick();
    bus.arvalid0_i = 1'b0;
    check("pend_arvalid", 64'(bus.arvalid_o), 64'd1);
    check("pend_src", 64'(gs), 64'd0);
    check("pend_cnt", 64'(os), 64'd5);

    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    check("arst_arvalid", 64'(bus.arvalid_o), 64'd0);
    check("arst_araddr", bus.araddr_o, 64'd0);
    check("arst_arid", 64'(bus.arid_o), 64'd0);
    check("arst_arlen", 64'(bus.arlen_o), 64'd0);
    check("arst_cnt", 64'(os), 64'd0);
    check("arst_arready", 64'(bus.arready0_o | bus.arready1_o), 64'd0);
    check("arst_src", 64'(gs), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.araddr0_i = 64'hA000; bus.araddr1_i = 64'hB000;
    bus.arvalid0_i = 1'b1; bus.arvalid1_i = 1'b1; bus.arready_i = 1'b1;
    tick();
    check("arst_tie_src", 64'(gs), 64'd0);
    check("arst_tie_arready0", 64'(bus.arready0_o), 64'd1);
    check("arst_tie_araddr", bus.araddr_o, 64'hA000);
    check("arst_no_replay_cnt", 64'(os), 64'd0);
    bus.arvalid0_i = 1'b0; bus.arvalid1_i = 1'b0;
    tick();

    // Outstanding limit of 2 on the second instance
    bus2.araddr0_i = 64'hC000; bus2.araddr1_i = 64'hD000;
    bus2.arvalid0_i = 1'b1; bus2.arvalid1_i = 1'b1; bus2.arready_i = 1'b1;
    tick(); tick(); tick(); tick();
    check("lim_cnt", 64'(os2), 64'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lim_blocked", 64'(bus2.arvalid_o), 64'd0);
      check("lim_no_ready", 64'(bus2.arready0_o | bus2.arready1_o), 64'd0);
    end
    bus2.rdone_i = 1'b1; tick(); bus2.rdone_i = 1'b0;
    check("lim_rdone_cnt", 64'(os2), 64'd1);
    check("lim_rdone_arvalid", 64'(bus2.arvalid_o), 64'd0);
    tick();
    check("lim_regrant", 64'(bus2.arvalid_o), 64'd1);
    check("lim_regrant_src", 64'(gs2), 64'd0);
    check("lim_regrant_addr", bus2.araddr_o, 64'hC000);
    tick();
    check("lim_cnt_back", 64'(os2), 64'd2);
    tick();
    check("lim_blocked_again", 64'(bus2.arvalid_o), 64'd0);
    check("lim_err", 64'(er2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
